// File: rtl/spi_flash_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_responder_if
// Purpose  : Byte-wide memory read bus between the SPI flash responder and
//            the backing store. Read data is valid exactly one clk after the
//            mem_rd strobe.
// Signals  : mem_rd    - one-cycle read strobe (responder -> memory)
//            mem_addr  - byte address for mem_rd (responder -> memory)
//            mem_rdata - read data, one clk after mem_rd (memory -> responder)
// Modports : master - responder side; slave - memory side
// Revision : 1.0 - initial release
// ============================================================================
interface spi_flash_responder_if #(
  parameter int MEM_AW = 24
) ();
  logic              mem_rd;
  logic [MEM_AW-1:0] mem_addr;
  logic [7:0]        mem_rdata;

  modport master (output mem_rd, output mem_addr, input mem_rdata);
  modport slave  (input mem_rd, input mem_addr, output mem_rdata);
endinterface
`default_nettype wire

// File: rtl/spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_responder
// Purpose  : SPI mode-0 flash emulator supporting the READ (0x03) command.
//            The SPI pins are oversampled by clk (>= 8x spi_clk); data bytes
//            are prefetched from a byte-wide memory bus.
// Ports    : clk, reset     - system clock, async active-high reset
//            spi_csb/clk/mosi - host SPI inputs (asynchronous to clk)
//            spi_miso, spi_miso_oe - responder data and pad output enable
//            mem            - memory read bus (master modport)
//            busy           - synchronized chip-select active
//            cmd_err        - one-cycle pulse on unsupported opcode
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_responder #(
  parameter int MEM_AW = 24
) (
  input  wire                   clk,
  input  wire                   reset,
  input  wire                   spi_csb,
  input  wire                   spi_clk,
  input  wire                   spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  spi_flash_responder_if.master mem,
  output logic                  busy,
  output logic                  cmd_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DATA   = 3'd3,
    IGNORE = 3'd4
  } state_t;

  // Synchronizers and edge detection
  logic       csb_meta_q, csb_sync_q;
  logic       sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic       mosi_meta_q, mosi_sync_q;
  logic [1:0] sync_fill_q;
  logic       armed_q;
  logic       sclk_rise, sclk_fall;

  // Protocol state
  state_t            state_q, state_d;
  logic [4:0]        bitcnt_q, bitcnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [23:0]       shift_in;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              rd_dly_q;
  logic              err_q, err_d;
  logic [7:0]        prefetch_q;
  logic [7:0]        txsr_q, txsr_d;
  logic              miso_q, miso_d;

  // sync_fill_q marks when csb_sync_q reflects the pin rather than its reset
  // value. armed_q then requires chip select to be seen high before a
  // transaction may start, so a csb held low across reset release is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csb_meta_q  <= 1'b1;
      csb_sync_q  <= 1'b1;
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      sync_fill_q <= 2'b00;
      armed_q     <= 1'b0;
    end else begin
      csb_meta_q  <= spi_csb;
      csb_sync_q  <= csb_meta_q;
      sclk_meta_q <= spi_clk;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      mosi_meta_q <= spi_mosi;
      mosi_sync_q <= mosi_meta_q;
      sync_fill_q <= {sync_fill_q[0], 1'b1};
      if (sync_fill_q[1] && csb_sync_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
  assign sclk_fall = ~sclk_sync_q & sclk_prev_q;
  assign shift_in  = {shift_q[22:0], mosi_sync_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bitcnt_q   <= 5'd0;
      shift_q    <= 24'd0;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      rd_dly_q   <= 1'b0;
      err_q      <= 1'b0;
      prefetch_q <= 8'd0;
      txsr_q     <= 8'd0;
      miso_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      rd_dly_q <= rd_q;
      err_q    <= err_d;
      txsr_q   <= txsr_d;
      miso_q   <= miso_d;
      if (rd_dly_q) begin
        prefetch_q <= mem.mem_rdata;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    addr_d   = addr_q;
    rd_d     = 1'b0;
    err_d    = 1'b0;
    txsr_d   = txsr_q;
    miso_d   = miso_q;

    case (state_q)
      IDLE: begin
        bitcnt_d = 5'd0;
        if (armed_q && !csb_sync_q) begin
          state_d = CMD;
        end
      end
      CMD: begin
        if (sclk_rise) begin
          shift_d  = shift_in;
          bitcnt_d = bitcnt_q + 5'd1;
          if (bitcnt_q == 5'd7) begin
            bitcnt_d = 5'd0;
            case (shift_in[7:0])
              8'h03:        state_d = ADDR;
              8'hAB, 8'hFF: state_d = IGNORE;
              default: begin
                state_d = IGNORE;
                err_d   = 1'b1;
              end
            endcase
          end
        end
      end
      ADDR: begin
        if (sclk_rise) begin
          shift_d  = shift_in;
          bitcnt_d = bitcnt_q + 5'd1;
          if (bitcnt_q == 5'd23) begin
            bitcnt_d = 5'd0;
            addr_d   = shift_in[MEM_AW-1:0];
            rd_d     = 1'b1;
            state_d  = DATA;
          end
        end
      end
      DATA: begin
        // bitcnt_q counts completed bits of the current byte; a fall with
        // bitcnt_q == 0 starts a new byte and pulls it from the prefetch.
        if (sclk_fall) begin
          if (bitcnt_q == 5'd0) begin
            miso_d = prefetch_q[7];
            txsr_d = {prefetch_q[6:0], 1'b0};
          end else begin
            miso_d = txsr_q[7];
            txsr_d = {txsr_q[6:0], 1'b0};
          end
        end else if (sclk_rise) begin
          bitcnt_d = bitcnt_q + 5'd1;
          if (bitcnt_q == 5'd7) begin
            bitcnt_d = 5'd0;
            addr_d   = addr_q + MEM_AW'(1);
            rd_d     = 1'b1;
          end
        end
      end
      IGNORE: begin
        bitcnt_d = 5'd0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Deselect wins over any spi_clk edge seen in the same cycle.
    if (state_q != IDLE && csb_sync_q) begin
      state_d  = IDLE;
      bitcnt_d = 5'd0;
      rd_d     = 1'b0;
      err_d    = 1'b0;
    end
  end

  assign spi_miso_oe  = (state_q == DATA) && !csb_sync_q;
  assign spi_miso     = spi_miso_oe & miso_q;
  assign mem.mem_rd   = rd_q;
  assign mem.mem_addr = addr_q;
  assign cmd_err      = err_q;
  assign busy         = ~csb_sync_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_spi_flash_responder
// Purpose  : Directed self-checking bench for spi_flash_responder. A simple
//            byte memory answers mem_rd one clk later; the host side is a
//            mode-0 SPI master running at clk/8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_flash_responder;

  logic clk      = 1'b0;
  logic reset    = 1'b0;
  logic spi_csb  = 1'b1;
  logic spi_clk  = 1'b0;
  logic spi_mosi = 1'b0;
  logic spi_miso, spi_miso_oe, busy, cmd_err;

  int checks = 0;
  int errors = 0;

  int unsigned rd_cnt  = 0;
  int unsigned oe_cnt  = 0;
  int unsigned err_cnt = 0;
  logic [23:0] rd_log [$];
  logic [7:0]  mem_model [bit [23:0]];

  spi_flash_responder_if #(.MEM_AW(24)) mif ();

  spi_flash_responder #(.MEM_AW(24)) dut (
    .clk         (clk),
    .reset       (reset),
    .spi_csb     (spi_csb),
    .spi_clk     (spi_clk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .mem         (mif),
    .busy        (busy),
    .cmd_err     (cmd_err)
  );

  always #5 clk = ~clk;

  // Memory model and event monitors
  always @(posedge clk) begin
    if (mif.mem_rd) begin
      rd_cnt <= rd_cnt + 1;
      rd_log.push_back(mif.mem_addr);
    end
    if (spi_miso_oe) oe_cnt <= oe_cnt + 1;
    if (cmd_err) err_cnt <= err_cnt + 1;
    mif.mem_rdata <= mem_model.exists(mif.mem_addr) ? mem_model[mif.mem_addr] : 8'h00;
  end

  // Host SPI primitives: data set while spi_clk is low, miso sampled just
  // before the rising edge, half period 40 ns (4 clk).
  task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = tx[i];
      #40;
      rx[i] = spi_miso;
      spi_clk = 1'b1;
      #40;
      spi_clk = 1'b0;
    end
  endtask

  task automatic xfer_bits(input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = 1'b0;
      #40;
      spi_clk = 1'b1;
      #40;
      spi_clk = 1'b0;
    end
  endtask

  task automatic select_dev();
    spi_csb = 1'b0;
    #100;
  endtask

  task automatic deselect_dev();
    spi_clk = 1'b0;
    spi_csb = 1'b1;
    #100;
  endtask

  task automatic send_read_hdr(input logic [23:0] a);
    logic [7:0] dummy;
    xfer_byte(8'h03, dummy);
    xfer_byte(a[23:16], dummy);
    xfer_byte(a[15:8], dummy);
    xfer_byte(a[7:0], dummy);
  endtask

  task automatic test_reset();
    #1;
    reset = 1'b1;
    #21;
    checks++;
    if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b expected 0", spi_miso_oe); end
    checks++;
    if (spi_miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", spi_miso); end
    checks++;
    if (mif.mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b expected 0", mif.mem_rd); end
    checks++;
    if (mif.mem_addr !== 24'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 000000", mif.mem_addr); end
    checks++;
    if (cmd_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_err_busy: got %b%b expected 00", cmd_err, busy); end
    reset = 1'b0;
    #100;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single_read();
    logic [7:0] rx, dummy;
    int unsigned oe0, rd0;
    int base;
    mem_model[24'h000010] = 8'hA5;
    oe0 = oe_cnt; rd0 = rd_cnt; base = rd_log.size();
    select_dev();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    xfer_byte(8'h03, dummy);
    xfer_byte(8'h00, dummy);
    checks++;
    if (oe_cnt != oe0 || spi_miso_oe !== 1'b0) begin errors++; $display("FAIL single_oe_hdr: got %0d oe cycles expected 0", oe_cnt - oe0); end
    xfer_byte(8'h00, dummy);
    xfer_byte(8'h10, dummy);
    xfer_byte(8'h00, rx);
    checks++;
    if (rx !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", rx); end
    checks++;
    if (spi_miso_oe !== 1'b1) begin errors++; $display("FAIL single_oe_data: got %b expected 1", spi_miso_oe); end
    deselect_dev();
    checks++;
    if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0) begin errors++; $display("FAIL single_oe_end: got %b%b expected 00", spi_miso_oe, spi_miso); end
    // One read for the byte plus the prefetch of the following address.
    checks++;
    if (rd_cnt - rd0 != 2 || rd_log[base] !== 24'h000010) begin errors++; $display("FAIL single_rd: got %0d reads first %h expected 2 first 000010", rd_cnt - rd0, rd_log[base]); end
  endtask

  task automatic test_burst();
    logic [7:0] rx [3];
    logic [23:0] exp_a [4];
    logic [7:0]  exp_d [3];
    int unsigned rd0;
    int base;
    exp_a[0] = 24'h0000FE; exp_a[1] = 24'h0000FF; exp_a[2] = 24'h000100; exp_a[3] = 24'h000101;
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    mem_model[24'h0000FE] = 8'h11;
    mem_model[24'h0000FF] = 8'h22;
    mem_model[24'h000100] = 8'h33;
    rd0 = rd_cnt; base = rd_log.size();
    select_dev();
    send_read_hdr(24'h0000FE);
    for (int i = 0; i < 3; i++) xfer_byte(8'h00, rx[i]);
    deselect_dev();
    checks++;
    if (rd_cnt - rd0 != 4) begin errors++; $display("FAIL burst_rd_count: got %0d expected 4", rd_cnt - rd0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_log[base + i] !== exp_a[i]) begin errors++; $display("FAIL burst_addr%0d: got %h expected %h", i, rd_log[base + i], exp_a[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rx[i] !== exp_d[i]) begin errors++; $display("FAIL burst_data%0d: got %h expected %h", i, rx[i], exp_d[i]); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] rx0, rx1;
    int base;
    mem_model[24'hFFFFFF] = 8'h5A;
    mem_model[24'h000000] = 8'hC3;
    base = rd_log.size();
    select_dev();
    send_read_hdr(24'hFFFFFF);
    xfer_byte(8'h00, rx0);
    xfer_byte(8'h00, rx1);
    deselect_dev();
    checks++;
    if (rd_log[base] !== 24'hFFFFFF || rd_log[base + 1] !== 24'h000000) begin errors++; $display("FAIL wrap_addr: got %h,%h expected ffffff,000000", rd_log[base], rd_log[base + 1]); end
    checks++;
    if (rx0 !== 8'h5A || rx1 !== 8'hC3) begin errors++; $display("FAIL wrap_data: got %h,%h expected 5a,c3", rx0, rx1); end
  endtask

  task automatic test_bad_opcode();
    logic [7:0] dummy;
    int unsigned rd0, oe0, err0;
    rd0 = rd_cnt; oe0 = oe_cnt; err0 = err_cnt;
    select_dev();
    xfer_byte(8'h9F, dummy);
    for (int i = 0; i < 3; i++) xfer_byte(8'h00, dummy);
    deselect_dev();
    checks++;
    if (err_cnt - err0 != 1) begin errors++; $display("FAIL bad_cmd_err: got %0d pulses expected 1", err_cnt - err0); end
    checks++;
    if (rd_cnt != rd0 || oe_cnt != oe0) begin errors++; $display("FAIL bad_cmd_quiet: got %0d reads %0d oe expected 0 0", rd_cnt - rd0, oe_cnt - oe0); end
    err0 = err_cnt;
    select_dev();
    xfer_byte(8'hAB, dummy);
    xfer_byte(8'h00, dummy);
    deselect_dev();
    checks++;
    if (err_cnt != err0 || rd_cnt != rd0) begin errors++; $display("FAIL ab_cmd: got %0d pulses %0d reads expected 0 0", err_cnt - err0, rd_cnt - rd0); end
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    int base;
    mem_model[24'h000020] = 8'h3C;
    mem_model[24'h000004] = 8'h96;
    select_dev();
    send_read_hdr(24'h000020);
    xfer_bits(3);
    checks++;
    if (spi_miso_oe !== 1'b1) begin errors++; $display("FAIL abort_oe_before: got %b expected 1", spi_miso_oe); end
    spi_csb = 1'b1;
    #30;
    checks++;
    if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL abort_oe_drop: got %b expected 0", spi_miso_oe); end
    #70;
    base = rd_log.size();
    select_dev();
    send_read_hdr(24'h000004);
    xfer_byte(8'h00, rx);
    deselect_dev();
    checks++;
    if (rx !== 8'h96 || rd_log[base] !== 24'h000004) begin errors++; $display("FAIL abort_reread: got %h at %h expected 96 at 000004", rx, rd_log[base]); end
  endtask

  task automatic test_reset_mid_addr();
    logic [7:0] rx, rx_a, rx_b, dummy;
    int unsigned rd0, oe0, err0;
    int base;
    mem_model[24'h000000] = 8'hC3;
    select_dev();
    xfer_byte(8'h03, dummy);
    xfer_byte(8'h00, dummy);
    reset = 1'b1;
    #20;
    checks++;
    if (spi_miso_oe !== 1'b0 || mif.mem_rd !== 1'b0) begin errors++; $display("FAIL midrst_in_reset: got oe %b rd %b expected 0 0", spi_miso_oe, mif.mem_rd); end
    reset = 1'b0;
    rd0 = rd_cnt; oe0 = oe_cnt; err0 = err_cnt;
    xfer_byte(8'h03, rx_a);
    xfer_byte(8'h00, rx_b);
    xfer_byte(8'h00, dummy);
    xfer_byte(8'h00, dummy);
    checks++;
    if (rd_cnt != rd0 || oe_cnt != oe0 || err_cnt != err0) begin errors++; $display("FAIL midrst_held_low: got %0d reads %0d oe %0d err expected 0 0 0", rd_cnt - rd0, oe_cnt - oe0, err_cnt - err0); end
    checks++;
    if (rx_a !== 8'h00 || rx_b !== 8'h00) begin errors++; $display("FAIL midrst_miso: got %h,%h expected 00,00", rx_a, rx_b); end
    deselect_dev();
    base = rd_log.size();
    select_dev();
    send_read_hdr(24'h000000);
    xfer_byte(8'h00, rx);
    deselect_dev();
    checks++;
    if (rx !== 8'hC3 || rd_log[base] !== 24'h000000) begin errors++; $display("FAIL midrst_reread: got %h at %h expected c3 at 000000", rx, rd_log[base]); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_burst();
    test_wrap();
    test_bad_opcode();
    test_abort();
    test_reset_mid_addr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
